register_bank: RTL
==================

# register_bank

Parametrised multi-register storage for the UL8 CPU datapath, the successor to the single 8-bit general-purpose register. Holds DEPTH registers of WIDTH bits, with one write port, two registered read ports, an in-place increment/decrement port for pointer registers (PC, SP), and a bus-drive port that replaces tri-state output with an explicit output-enable. Sits between the control unit and the ALU/data bus.

## Interface
- WIDTH, 8, bits per register (≥ 2)
- DEPTH, 8, number of registers (power of two, ≥ 2)
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes and steps
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write wr_data into register wr_addr
- wr_addr  in  log2(DEPTH)  write address
- wr_data  in  WIDTH  write data
- rd_a_addr, rd_b_addr  in  log2(DEPTH)  read addresses, sampled every cycle
- rd_a_data, rd_b_data  out  WIDTH  registered read data
- step_op  in  2  00 none, 01 increment, 10 decrement, 11 reserved (treated as none)
- step_addr  in  log2(DEPTH)  register to step
- step_wrap  out  1  registered one-cycle pulse: the step wrapped around
- bus_en  in  1  request that register bus_addr be driven onto the bus
- bus_addr  in  log2(DEPTH)  bus source register
- bus_data  out  WIDTH  registered bus value; 0 when bus_oe is low
- bus_oe  out  1  registered; high when bus_data is valid to drive

## Operation
- Reset, asynchronous and active-high, clears every register, rd_a_data, rd_b_data, bus_data, bus_oe and step_wrap to 0.
- Next value for register r in each cycle:
  - If wr_en and wr_addr == r, it becomes wr_data.
  - Else if step_op is inc or dec and step_addr == r, it becomes r ± 1 modulo 2^WIDTH.
  - Else it holds.
- Write wins over step. A step suppressed by a write asserts no step_wrap.
- step_wrap is 1 in the next cycle when an applied increment took all-ones to 0, or an applied decrement took 0 to all-ones. Otherwise it is 0.
- Read ports are write-first. Each rd_x_data gets the next value of register rd_x_addr, including a same-cycle write or step.
- The bus port is also write-first.
  - If bus_en=1: bus_oe=1 and bus_data = next value of register bus_addr.
  - If bus_en=0: bus_oe=0 and bus_data=0.
  - A simultaneous write to bus_addr does not suppress the drive. This is unlike the old register, where load and write together gave high-Z.
- ZERO_REG=1:
  - Writes and steps to address 0 are discarded, and step_wrap stays 0 for them.
  - All ports read address 0 as 0.
- Any read port, bus port and step may target the same register in the same cycle.

## Timing
- Read latency is 1 cycle: address at edge N gives data valid after edge N+1, reflecting state as of edge N+1.
- A write at edge N is visible on any port sampled at edge N, through the write-first bypass.
- Step and write have a throughput of one operation per cycle each. Back-to-back increments of the same register accumulate: k cycles of increment add k.
- Reset asserted mid-operation clears state immediately; outputs read 0 while reset is high. The first edge after deassertion performs normal operation.
- No combinational path from any input to any output.

## Structure
- Shared package ul8_pkg holds:
  - step_op encoding constants: STEP_NONE, STEP_INC, STEP_DEC.
  - Default WIDTH/DEPTH constants.
- One sub-module, reg_step_cell: a single WIDTH-bit register with write, step and wrap detection, instantiated DEPTH times.
- Read and bus multiplexing and the bypass live in register_bank.

## Test plan
- Reset: write 0xA5 to all 8 registers, assert reset mid-cycle → all outputs 0 at once; reading each register after release → 0x00.
- Write/read: write 0x3C to r5, then read r5 on port A and r2 on port B → rd_a_data=0x3C, rd_b_data=0x00. Same-cycle write 0x77 to r3 with rd_b_addr=3 → rd_b_data=0x77 next cycle.
- Step wrap:
  - r1=0xFE, increment 3 cycles → r1 reads 0xFF, 0x00, 0x01; step_wrap pulses only on the 0xFF→0x00 cycle.
  - r2=0x00, decrement → r2=0xFF with step_wrap=1.
- Collision: r4=0x10, wr_en to r4 with 0x50 plus increment of r4 in the same cycle → r4=0x50, step_wrap=0.
- Bus: bus_en=1, bus_addr=6 with r6=0x9A → bus_oe=1, bus_data=0x9A. bus_en=0 → bus_oe=0, bus_data=0x00. Same-cycle write of 0x11 to r6 → bus_data=0x11.
- ZERO_REG=1, WIDTH=16, DEPTH=4: write 0xBEEF to r0 and increment r0 → r0 reads 0x0000, step_wrap=0. Write 0xFFFF to r3 then increment → 0x0000 with wrap pulse.

Source files
------------

// File: rtl/ul8_pkg.sv
// Shared constants for the UL8 datapath register bank.
//   STEP_*         : step_op encodings (2'b11 is reserved and behaves as STEP_NONE)
//   DEFAULT_WIDTH  : default bits per register
//   DEFAULT_DEPTH  : default number of registers
package ul8_pkg;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_INC  = 2'b01;
    localparam logic [1:0] STEP_DEC  = 2'b10;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

endpackage

// File: rtl/reg_step_cell.sv
// One WIDTH-bit register with load, in-place increment/decrement and wrap detection.
//   clk, reset  : clock, asynchronous active-high reset (clears the register)
//   wr_i        : load wr_data_i (takes priority over any step)
//   wr_data_i   : load value
//   step_op_i   : step request already decoded for this cell (STEP_NONE when not selected)
//   val_d_o     : next value of the register (used by the bank's write-first bypass)
//   wrap_o      : the step being applied this cycle wraps around
module reg_step_cell
    import ul8_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [1:0]       step_op_i,
    output logic [WIDTH-1:0] val_d_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic             wrap;

    always_comb begin
        val_d = val_q;
        wrap  = 1'b0;
        if (wr_i) begin
            // A write suppresses the step entirely, including its wrap report.
            val_d = wr_data_i;
        end else if (step_op_i == STEP_INC) begin
            val_d = val_q + One;
            wrap  = &val_q;
        end else if (step_op_i == STEP_DEC) begin
            val_d = val_q - One;
            wrap  = ~|val_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_d_o = val_d;
    assign wrap_o  = wrap;

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank: one write port, two registered write-first read ports,
// an increment/decrement step port with wrap pulse, and a registered bus-drive port.
//   clk, reset            : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : write port
//   rd_a_addr, rd_b_addr  : read addresses; rd_a_data, rd_b_data registered results
//   step_op, step_addr    : step request; step_wrap registered wrap pulse
//   bus_en, bus_addr      : bus request; bus_data/bus_oe registered drive (data 0 when idle)
// With ZERO_REG != 0, register 0 is hard-wired to zero on every port.
module register_bank
    import ul8_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic [1:0]       step_op,
    input  logic [AW-1:0]    step_addr,
    output logic             step_wrap,
    input  logic             bus_en,
    input  logic [AW-1:0]    bus_addr,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_oe
);

    logic [WIDTH-1:0] nxt [DEPTH];
    logic [DEPTH-1:0] wrap;

    for (genvar r = 0; r < DEPTH; r++) begin : g_cell
        localparam logic [AW-1:0] Addr = AW'(r);
        // A hard-wired zero register never loads or steps, so it stays at its reset value.
        localparam bit Frozen = (ZERO_REG != 0) && (r == 0);

        logic       cell_wr;
        logic [1:0] cell_step;

        assign cell_wr   = wr_en && (wr_addr == Addr) && !Frozen;
        assign cell_step = ((step_addr == Addr) && !Frozen) ? step_op : STEP_NONE;

        reg_step_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .wr_i     (cell_wr),
            .wr_data_i(wr_data),
            .step_op_i(cell_step),
            .val_d_o  (nxt[r]),
            .wrap_o   (wrap[r])
        );
    end

    // Write-first view of a register: its value after the coming edge.
    function automatic logic [WIDTH-1:0] pick(input logic [AW-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) begin
            return '0;
        end
        return nxt[a];
    endfunction

    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             bus_oe_q, bus_oe_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        rd_a_d     = pick(rd_a_addr);
        rd_b_d     = pick(rd_b_addr);
        bus_oe_d   = bus_en;
        bus_data_d = bus_en ? pick(bus_addr) : '0;
        // Only one register is stepped per cycle, so at most one bit is set.
        wrap_d     = |wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            bus_data_q <= '0;
            bus_oe_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            bus_data_q <= bus_data_d;
            bus_oe_q   <= bus_oe_d;
            wrap_q     <= wrap_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign bus_data  = bus_data_q;
    assign bus_oe    = bus_oe_q;
    assign step_wrap = wrap_q;

endmodule
